// File: rtl/osd_avalon_pkg.sv
// rtl/osd_avalon_pkg.sv - shared constants and FSM encoding for the OSD Avalon-MM master
package osd_avalon_pkg;

  localparam int DATA_W             = 32;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int LAT_W              = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_RDLAT = 2'd2
  } state_e;

endpackage

// File: rtl/osd_avalon_master.sv
// rtl/osd_avalon_master.sv - command/response to Avalon-MM master for the OSD register file
// Optional waitrequest timeout abort enabled by defining OSD_AVM_TIMEOUT_EN.
module osd_avalon_master
  import osd_avalon_pkg::*;
#(
  parameter int ADDR_WIDTH     = 3,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_W-1:0]     cmd_writedata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_readdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] av_address,
  output logic                  av_read,
  output logic                  av_write,
  output logic [DATA_W-1:0]     av_writedata,
  input  logic [DATA_W-1:0]     av_readdata,
  input  logic                  av_waitrequest
);

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0] av_address_q, av_address_d;
  logic                  av_read_q, av_read_d;
  logic                  av_write_q, av_write_d;
  logic [DATA_W-1:0]     av_writedata_q, av_writedata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_readdata_q, rsp_readdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [LAT_W-1:0]      lat_q, lat_d;

`ifdef OSD_AVM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tout_q, tout_d;
`endif

  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready_q;
    av_address_d   = av_address_q;
    av_read_d      = av_read_q;
    av_write_d     = av_write_q;
    av_writedata_d = av_writedata_q;
    rsp_valid_d    = 1'b0;
    rsp_readdata_d = rsp_readdata_q;
    rsp_error_d    = rsp_error_q;
    lat_d          = lat_q;
`ifdef OSD_AVM_TIMEOUT_EN
    tout_d         = tout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          av_address_d   = cmd_address;
          av_writedata_d = cmd_writedata;
          av_write_d     = cmd_write;
          av_read_d      = !cmd_write;
          cmd_ready_d    = 1'b0;
          state_d        = ST_BUS;
`ifdef OSD_AVM_TIMEOUT_EN
          tout_d         = '0;
`endif
        end
      end
      ST_BUS: begin
        if (!av_waitrequest) begin
          av_read_d  = 1'b0;
          av_write_d = 1'b0;
          if (av_write_q) begin
            state_d        = ST_IDLE;
            cmd_ready_d    = 1'b1;
            rsp_valid_d    = 1'b1;
            rsp_readdata_d = '0;
            rsp_error_d    = 1'b0;
          end else begin
            lat_d   = LAT_W'(READ_LATENCY - 1);
            state_d = ST_RDLAT;
          end
        end
`ifdef OSD_AVM_TIMEOUT_EN
        // Abort on the TIMEOUT_CYCLES-th consecutive stalled edge.
        else if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
          av_read_d      = 1'b0;
          av_write_d     = 1'b0;
          state_d        = ST_IDLE;
          cmd_ready_d    = 1'b1;
          rsp_valid_d    = 1'b1;
          rsp_readdata_d = '0;
          rsp_error_d    = 1'b1;
        end else begin
          tout_d = tout_q + 1'b1;
        end
`endif
      end
      ST_RDLAT: begin
        if (lat_q == '0) begin
          rsp_readdata_d = av_readdata;
          rsp_valid_d    = 1'b1;
          rsp_error_d    = 1'b0;
          cmd_ready_d    = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cmd_ready_q    <= 1'b1;
      av_address_q   <= '0;
      av_read_q      <= 1'b0;
      av_write_q     <= 1'b0;
      av_writedata_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_readdata_q <= '0;
      rsp_error_q    <= 1'b0;
      lat_q          <= '0;
`ifdef OSD_AVM_TIMEOUT_EN
      tout_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      av_address_q   <= av_address_d;
      av_read_q      <= av_read_d;
      av_write_q     <= av_write_d;
      av_writedata_q <= av_writedata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_readdata_q <= rsp_readdata_d;
      rsp_error_q    <= rsp_error_d;
      lat_q          <= lat_d;
`ifdef OSD_AVM_TIMEOUT_EN
      tout_q         <= tout_d;
`endif
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign av_address   = av_address_q;
  assign av_read      = av_read_q;
  assign av_write     = av_write_q;
  assign av_writedata = av_writedata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_readdata = rsp_readdata_q;
  assign rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_osd_avalon_master.sv
// tb/tb_osd_avalon_master.sv - self-checking bench for osd_avalon_master (OSD_AVM_TIMEOUT_EN adds the timeout scenario)
module tb_osd_avalon_master;

  localparam int AW = 3;
  localparam int RL = 1;
`ifdef OSD_AVM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_address;
  logic [31:0]   cmd_writedata;
  logic          rsp_valid, rsp_error;
  logic [31:0]   rsp_readdata;
  logic [AW-1:0] av_address;
  logic          av_read, av_write, av_waitrequest;
  logic [31:0]   av_writedata, av_readdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem   [8];
  logic [31:0] slave_mem [8];
  logic [31:0] last_rd;

  osd_avalon_master #(
    .ADDR_WIDTH(AW), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_error(rsp_error),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest)
  );

  always #5 clk = ~clk;

  // Issues one command from the current negedge and returns at the negedge where rsp_valid is seen.
  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                         input int stall, input bit junk, output int lat);
    logic [31:0]   exp_rd;
    logic          exp_err;
    int            exp_lat, exp_strobes, strobes, rd_cycle;
    logic [AW-1:0] rd_addr;
    bit            done, timed_out;
    timed_out = 1'b0;
`ifdef OSD_AVM_TIMEOUT_EN
    timed_out = (stall >= TO);
`endif
    if (timed_out) begin
      exp_rd = 32'd0; exp_err = 1'b1; exp_lat = TO + 1; exp_strobes = TO;
    end else begin
      exp_rd      = w ? 32'd0 : ref_mem[a];
      exp_err     = 1'b0;
      exp_lat     = 2 + stall + (w ? 0 : RL);
      exp_strobes = stall + 1;
      if (w) ref_mem[a] = d;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_before_cmd: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_writedata = d;
    av_waitrequest = 1'b0; av_readdata = $urandom;
    @(posedge clk);
    strobes = 0; lat = -1; done = 1'b0; rd_cycle = -1; rd_addr = '0;
    for (int k = 1; k <= 64 && !done; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; done = 1'b1; last_rd = rsp_readdata;
        cmd_valid = 1'b0;
      end else begin
        av_waitrequest = (k <= stall);
        if (av_read || av_write) begin
          strobes++;
          checks++;
          if (av_write !== w || av_read !== !w || av_address !== a || (w && av_writedata !== d)) begin
            errors++;
            $display("FAIL strobe_cycle%0d: got rd=%b wr=%b addr=%0d wd=%h expected rd=%b wr=%b addr=%0d wd=%h",
                     k, av_read, av_write, av_address, av_writedata, !w, w, a, d);
          end
          if (!av_waitrequest && av_write) slave_mem[av_address] = av_writedata;
          if (!av_waitrequest && av_read) begin
            rd_addr = av_address; rd_cycle = k + RL;
          end
        end
        av_readdata = (k == rd_cycle) ? slave_mem[rd_addr] : $urandom;
        if (junk && !cmd_ready) begin
          cmd_valid = 1'($urandom_range(0, 1)); cmd_write = 1'($urandom_range(0, 1));
          cmd_address = AW'($urandom); cmd_writedata = $urandom;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL rsp_latency: got %0d expected %0d", lat, exp_lat);
    end
    checks++;
    if (rsp_readdata !== exp_rd || rsp_error !== exp_err) begin
      errors++; $display("FAIL rsp_data: got %h err=%b expected %h err=%b", rsp_readdata, rsp_error, exp_rd, exp_err);
    end
    checks++;
    if (strobes !== exp_strobes) begin
      errors++; $display("FAIL strobe_count: got %0d expected %0d", strobes, exp_strobes);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0; av_waitrequest = 1'($urandom_range(0, 1)); av_readdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_readdata !== last_rd || cmd_ready !== 1'b1 || av_read !== 1'b0 || av_write !== 1'b0) begin
        errors++;
        $display("FAIL idle_state: got v=%b rd=%h rdy=%b r=%b w=%b expected v=0 rd=%h rdy=1 r=0 w=0",
                 rsp_valid, rsp_readdata, cmd_ready, av_read, av_write, last_rd);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_readdata !== 32'd0 || rsp_error !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got rdy=%b v=%b rd=%h err=%b expected 1 0 0 0", cmd_ready, rsp_valid, rsp_readdata, rsp_error);
    end
    checks++;
    if (av_read !== 1'b0 || av_write !== 1'b0 || av_address !== '0 || av_writedata !== 32'd0) begin
      errors++; $display("FAIL reset_av: got r=%b w=%b a=%0d wd=%h expected all 0", av_read, av_write, av_address, av_writedata);
    end
    rst = 1'b0;
    last_rd = 32'd0;
  endtask

  task automatic test_write();
    int lat;
    run_cmd(1'b1, 3'd2, 32'h1234_5678, 0, 1'b0, lat);
    checks++;
    if (lat !== 2 || slave_mem[2] !== 32'h1234_5678) begin
      errors++; $display("FAIL write_basic: got lat=%0d mem=%h expected lat=2 mem=12345678", lat, slave_mem[2]);
    end
    idle(2);
  endtask

  task automatic test_read();
    int lat;
    ref_mem[4] = 32'hDEAD_BEEF; slave_mem[4] = 32'hDEAD_BEEF;
    run_cmd(1'b0, 3'd4, 32'd0, 0, 1'b0, lat);
    checks++;
    if (lat !== 3 || rsp_readdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_basic: got lat=%0d data=%h expected lat=3 data=deadbeef", lat, rsp_readdata);
    end
    idle(1);
  endtask

  task automatic test_stall();
    int lat;
    run_cmd(1'b0, 3'd6, 32'd0, 3, 1'b1, lat);
    checks++;
    if (lat !== 6) begin
      errors++; $display("FAIL stall_read_latency: got %0d expected 6", lat);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int lat;
    run_cmd(1'b1, 3'd5, 32'h0000_00A5, 0, 1'b0, lat);
    run_cmd(1'b0, 3'd5, 32'd0, 0, 1'b0, lat);
    checks++;
    if (rsp_readdata !== 32'h0000_00A5 || lat !== 3) begin
      errors++; $display("FAIL back_to_back: got data=%h lat=%0d expected data=000000a5 lat=3", rsp_readdata, lat);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 3'd5; av_waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; av_readdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || av_read !== 1'b0 || rsp_valid !== 1'b0 || rsp_readdata !== 32'd0) begin
      errors++; $display("FAIL reset_mid_read: got rdy=%b r=%b v=%b rd=%h expected 1 0 0 0", cmd_ready, av_read, rsp_valid, rsp_readdata);
    end
    last_rd = 32'd0;
    idle(8);
  endtask

  task automatic test_random();
    int lat;
    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom_range(0, 3), 1'b1, lat);
      idle($urandom_range(0, 2));
    end
  endtask

`ifdef OSD_AVM_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    run_cmd(1'b0, 3'd3, 32'd0, 1000, 1'b1, lat);
    checks++;
    if (rsp_error !== 1'b1 || lat !== TO + 1) begin
      errors++; $display("FAIL timeout: got err=%b lat=%0d expected err=1 lat=%0d", rsp_error, lat, TO + 1);
    end
    idle(2);
  endtask
`endif

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_writedata = '0;
    av_readdata = '0; av_waitrequest = 1'b0; last_rd = '0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = $urandom; slave_mem[i] = ref_mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
`ifdef OSD_AVM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_avalon_master.md
Name: osd_avalon_master

Overview:
- Avalon-MM master that drives the OSD register-file slave from a simple command/response stream.
- Typical users are a host sequencer or boot-time register loader in the OSD generator.
- Each accepted command becomes exactly one Avalon read or write, honouring waitrequest and a fixed read latency.
- Each command returns exactly one response pulse.

Parameters:
- ADDR_WIDTH, 3, Avalon word-address width; must match the slave.
- READ_LATENCY, 1, fixed slave read latency in cycles; legal range 1..15.
- TIMEOUT_CYCLES, 255, waitrequest cycles before abort; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  master idle; command accepted when cmd_valid && cmd_ready at a clk edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_WIDTH  target word address
- cmd_writedata  in  32  write data
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_readdata  out  32  read data; 0 for writes
- rsp_error  out  1  transfer aborted by timeout; valid with rsp_valid
- av_address  out  ADDR_WIDTH  Avalon address
- av_read  out  1  Avalon read strobe
- av_write  out  1  Avalon write strobe
- av_writedata  out  32  Avalon write data
- av_readdata  in  32  Avalon read data
- av_waitrequest  in  1  slave stall; tie 0 for slaves without stall

Behaviour:
- All outputs are registered.
- Reset values:
  - cmd_ready = 1 (IDLE).
  - All av_* outputs = 0.
  - rsp_valid = 0, rsp_readdata = 0, rsp_error = 0.
- FSM states: IDLE, BUS, RDLAT.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch cmd_address and cmd_writedata into av_address and av_writedata; set av_write = cmd_write and av_read = !cmd_write; go to BUS.
  - cmd_ready drops in the cycle after accept.
- BUS:
  - Strobe and address are held stable while av_waitrequest = 1.
  - The transfer is accepted at the first edge with av_waitrequest = 0. On that edge, strobes clear.
  - Write: go to IDLE with rsp_valid = 1 and rsp_readdata = 0.
  - Read: load the latency counter with READ_LATENCY−1 and go to RDLAT.
- RDLAT:
  - Counter decrements each cycle.
  - At the edge where the counter equals 0, capture av_readdata into rsp_readdata, pulse rsp_valid and go to IDLE.
  - With READ_LATENCY = 1, av_readdata is sampled at the edge one cycle after acceptance.
- Command-to-response timing with no stalls:
  - Write: rsp_valid in the 2nd cycle after the accept edge.
  - Read: rsp_valid in the (2+READ_LATENCY)th cycle after the accept edge.
- cmd_ready and rsp_valid go high in the same cycle. A new command may be accepted that cycle, so back-to-back throughput is one command per 2 + latency cycles.
- cmd_valid while cmd_ready = 0 is ignored; the command is not queued.
- av_readdata is ignored outside the sample edge.
- rsp_valid is held high for exactly one cycle. rsp_readdata holds its value until the next response.
- rst mid-transfer:
  - Next cycle is IDLE with all outputs at reset values.
  - The pending response is dropped; no rsp_valid.
  - A slave-side read already in flight is discarded.

Optional Feature:
- Macro OSD_AVM_TIMEOUT_EN.
- Defined:
  - A counter runs in BUS while av_waitrequest = 1.
  - After TIMEOUT_CYCLES consecutive stalled cycles, strobes clear and the FSM goes to IDLE with rsp_valid = 1, rsp_error = 1, rsp_readdata = 0.
  - The counter clears on each new command.
- Undefined:
  - No counter logic; rsp_error is constant 0.
  - BUS waits indefinitely.

Decomposition:
- Package osd_avalon_pkg holds:
  - data-width constant 32;
  - FSM state encoding (IDLE/BUS/RDLAT);
  - TIMEOUT_CYCLES default value.
- No sub-module. Latency and timeout counters are small and stay inline.

Test Plan:
- Write, no stall: cmd write addr 2, data 0x12345678 → av_write = 1 for 1 cycle with av_address = 2; rsp_valid in the 2nd cycle after accept, rsp_readdata = 0.
- Read, READ_LATENCY = 1: slave returns 0xDEADBEEF one cycle after acceptance → rsp_readdata = 0xDEADBEEF, rsp_valid in the 3rd cycle after accept.
- Waitrequest stall: hold av_waitrequest = 1 for 3 cycles on a read → av_read and av_address stable for 4 cycles; response 3 cycles later than unstalled; cmd_valid pulses during the stall are ignored.
- Back-to-back: write 0xA5 to addr 5, then read addr 5 against a register-file slave model → rsp_readdata = 0xA5; second command accepted in the same cycle as the first rsp_valid.
- Reset mid-read: assert rst in RDLAT → next cycle cmd_ready = 1, av_read = 0, no rsp_valid ever appears for that read.
- Timeout (macro defined, TIMEOUT_CYCLES = 4): waitrequest stuck high → strobes clear after 4 stalled cycles; rsp_valid = 1, rsp_error = 1.
